// File: rtl/mem_access_unit.sv
// mem_access_unit: turns single CPU load/store requests into the RAM addr/data/control_signal pattern.
// Optional one-entry read buffer is compiled in by defining MAU_RDBUF_EN.
module mem_access_unit #(
   parameter int ADDR_W       = 8,
   parameter int DATA_W       = 16,
   parameter int READ_LATENCY = 1,
   parameter int WE_BIT       = 12,
   parameter int RE_BIT       = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   input  logic [DATA_W-1:0] ram_dout,
   output logic [31:0]       ram_ctrl
);

   typedef enum logic [2:0] {
      IDLE,
      WR_ARM,
      WR_COMMIT,
      RD_ISSUE,
      RD_WAIT,
      RESP
   } state_t;

   localparam logic [31:0] WE_MASK = 32'(1) << WE_BIT;
   localparam logic [31:0] RE_MASK = 32'(1) << RE_BIT;
   localparam logic [1:0]  RD_CNT_INIT = 2'(READ_LATENCY - 1);

   if (READ_LATENCY < 1 || READ_LATENCY > 3) begin : g_bad_latency
      $error("mem_access_unit: READ_LATENCY must be 1..3");
   end

   state_t     state;
   logic [1:0] rd_cnt;
   logic       rd_done;
   logic       buf_hit;

   // Ready is gated by rst directly so no request can be taken during a reset cycle.
   assign req_ready = (state == IDLE) && !rst;
   assign rd_done   = (state == RD_WAIT) && (rd_cnt == 2'd0);

`ifdef MAU_RDBUF_EN
   logic              buf_valid;
   logic [ADDR_W-1:0] buf_addr;
   logic [DATA_W-1:0] buf_data;

   assign buf_hit = buf_valid && (buf_addr == req_addr);

   always_ff @(posedge clk) begin
      if (rst) begin
         buf_valid <= 1'b0;
      end else if (state == WR_COMMIT || rd_done) begin
         buf_valid <= 1'b1;
      end
   end

   // NOTE: the buffer payload has no reset; buf_valid alone decides whether it is meaningful.
   always_ff @(posedge clk) begin
      if (state == WR_COMMIT) begin
         buf_addr <= ram_addr;
         buf_data <= ram_din;
      end else if (rd_done) begin
         buf_addr <= ram_addr;
         buf_data <= ram_dout;
      end
   end
`else
   assign buf_hit = 1'b0;
`endif

   // NOTE: all state and registered outputs use non-blocking assignments so every update sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ram_ctrl  <= '0;
         ram_addr  <= '0;
         ram_din   <= '0;
         rsp_rdata <= '0;
         rsp_valid <= 1'b0;
         rd_cnt    <= '0;
      end else begin
         ram_ctrl  <= '0;
         rsp_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (req_valid) begin
                  ram_addr <= req_addr;
                  if (req_we) begin
                     ram_din  <= req_wdata;
                     ram_ctrl <= WE_MASK;
                     state    <= WR_ARM;
                  end else if (buf_hit) begin
`ifdef MAU_RDBUF_EN
                     rsp_rdata <= buf_data;
`endif
                     rsp_valid <= 1'b1;
                     state     <= RESP;
                  end else begin
                     ram_ctrl <= RE_MASK;
                     state    <= RD_ISSUE;
                  end
               end
            end
            // The RAM registers its write enable here; address and data must not move for two cycles.
            WR_ARM:    state <= WR_COMMIT;
            WR_COMMIT: begin
               rsp_valid <= 1'b1;
               state     <= RESP;
            end
            RD_ISSUE: begin
               rd_cnt <= RD_CNT_INIT;
               state  <= RD_WAIT;
            end
            RD_WAIT: begin
               if (rd_done) begin
                  rsp_rdata <= ram_dout;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end else begin
                  rd_cnt <= rd_cnt - 2'd1;
               end
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: vector table, hand-written corner sequences and a
// randomized run against a request-level reference model (honours MAU_RDBUF_EN).
module tb_mem_access_unit;

   localparam int RL = 1;
   localparam int WE_BIT = 12;
   localparam int RE_BIT = 5;
   localparam logic [31:0] WE_MASK = 32'h0000_1000;
   localparam logic [31:0] RE_MASK = 32'h0000_0020;
`ifdef MAU_RDBUF_EN
   localparam bit HIT = 1'b1;
`else
   localparam bit HIT = 1'b0;
`endif
   localparam int HIT_LAT = HIT ? 1 : RL + 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        req_valid = 1'b1, req_we = 1'b0, req_ready, rsp_valid;
   logic [7:0]  req_addr = '0, ram_addr;
   logic [15:0] req_wdata = '0, rsp_rdata, ram_din, ram_dout;
   logic [31:0] ram_ctrl;

   logic        v3 = 1'b0, we3 = 1'b0, ready3, rsp_valid3;
   logic [7:0]  a3 = '0, ram_addr3;
   logic [15:0] wd3 = '0, rsp_rdata3, ram_din3, ram_dout3;
   logic [31:0] ram_ctrl3;

   mem_access_unit #(.ADDR_W(8), .DATA_W(16), .READ_LATENCY(RL), .WE_BIT(WE_BIT), .RE_BIT(RE_BIT)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout), .ram_ctrl(ram_ctrl));

   mem_access_unit #(.ADDR_W(8), .DATA_W(16), .READ_LATENCY(3), .WE_BIT(WE_BIT), .RE_BIT(RE_BIT)) dut3 (
      .clk(clk), .rst(rst), .req_valid(v3), .req_ready(ready3), .req_we(we3),
      .req_addr(a3), .req_wdata(wd3), .rsp_valid(rsp_valid3), .rsp_rdata(rsp_rdata3),
      .ram_addr(ram_addr3), .ram_din(ram_din3), .ram_dout(ram_dout3), .ram_ctrl(ram_ctrl3));

   // Block-RAM models: write enable registered once, read data after the configured latency.
   logic [15:0] mem1 [256];
   logic [15:0] mem3 [256];
   logic        we_q1 = 1'b0, we_q3 = 1'b0;
   logic [15:0] r1_0 = '0, r3_0 = '0, r3_1 = '0, r3_2 = '0;
   always @(posedge clk) begin
      we_q1 <= ram_ctrl[WE_BIT];
      if (we_q1) mem1[ram_addr] <= ram_din;
      if (ram_ctrl[RE_BIT]) r1_0 <= mem1[ram_addr];
      we_q3 <= ram_ctrl3[WE_BIT];
      if (we_q3) mem3[ram_addr3] <= ram_din3;
      if (ram_ctrl3[RE_BIT]) r3_0 <= mem3[ram_addr3];
      r3_1 <= r3_0;
      r3_2 <= r3_1;
   end
   assign ram_dout  = r1_0;
   assign ram_dout3 = r3_2;

   // Reference model: memory contents plus the optional one-entry buffer.
   logic [15:0] ref_mem [256];
   bit          buf_v = 1'b0;
   logic [7:0]  buf_a = '0;
   logic [15:0] buf_d = '0;
   logic [15:0] last_din = '0;

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic bit model_hit(input logic [7:0] a);
      return HIT && buf_v && (buf_a == a);
   endfunction

   task automatic model_apply(input logic we, input logic [7:0] a, input logic [15:0] wd);
      if (we) begin
         ref_mem[a] = wd;
         last_din   = wd;
      end
      buf_v = 1'b1;
      buf_a = a;
      buf_d = ref_mem[a];
   endtask

   // Issues one request and observes it until req_ready returns.
   task automatic verify(input string tag, input logic we, input logic [7:0] a, input logic [15:0] wd,
                         input int exp_lat, input logic [15:0] exp_rd, input bit exp_re);
      int          waited = 0;
      int          rsp_cyc = 0;
      int          rsp_cnt = 0;
      logic [15:0] got = '0;
      logic [15:0] we_m = '0;
      logic [15:0] re_m = '0;
      logic [15:0] exp_din;
      bit          other = 1'b0, hold_ok = 1'b1, busy_ok = 1'b1, back = 1'b0;
      exp_din   = we ? wd : last_din;
      req_we    = we;
      req_addr  = a;
      req_wdata = wd;
      req_valid = 1'b1;
      while (!req_ready && waited < 20) begin
         step();
         waited++;
      end
      if (!req_ready) begin
         check({tag, ".accept_timeout"}, 0, 1);
         req_valid = 1'b0;
         return;
      end
      step();
      req_valid = 1'b0;
      req_addr  = 8'($urandom);
      req_wdata = 16'($urandom);
      for (int c = 1; c <= 12; c++) begin
         if (ram_ctrl[WE_BIT]) we_m[c] = 1'b1;
         if (ram_ctrl[RE_BIT]) re_m[c] = 1'b1;
         if ((ram_ctrl & ~(WE_MASK | RE_MASK)) != 0 || (ram_ctrl[WE_BIT] && ram_ctrl[RE_BIT])) other = 1'b1;
         if (ram_addr !== a || ram_din !== exp_din) hold_ok = 1'b0;
         if (rsp_valid) begin
            rsp_cnt++;
            if (rsp_cyc == 0) begin
               rsp_cyc = c;
               got     = rsp_rdata;
            end
         end
         if (rsp_cyc == 0 || c == rsp_cyc) begin
            if (req_ready) busy_ok = 1'b0;
         end else begin
            back = req_ready;
            break;
         end
         step();
      end
      check({tag, ".lat"}, rsp_cyc, exp_lat);
      check({tag, ".rsp_cnt"}, rsp_cnt, 1);
      check({tag, ".busy"}, busy_ok, 1);
      check({tag, ".ready_back"}, back, 1);
      check({tag, ".hold"}, hold_ok, 1);
      check({tag, ".ctrl_other"}, other, 0);
      check({tag, ".we_pulse"}, we_m, we ? 16'h0002 : 16'h0000);
      check({tag, ".re_pulse"}, re_m, (!we && exp_re) ? 16'h0002 : 16'h0000);
      if (!we) check({tag, ".rdata"}, got, exp_rd);
      model_apply(we, a, wd);
   endtask

   typedef struct {
      logic        we;
      logic [7:0]  addr;
      logic [15:0] wdata;
      int          lat;
      logic [15:0] rdata;
      bit          re;
   } vec_t;

   initial begin
      vec_t vecs [11];
      int   rsp3_cyc;
      logic [15:0] rsp3_data;

      for (int i = 0; i < 256; i++) begin
         mem1[i]    = {i[7:0], ~i[7:0]};
         mem3[i]    = {i[7:0], ~i[7:0]};
         ref_mem[i] = {i[7:0], ~i[7:0]};
      end

      vecs[0]  = '{1'b1, 8'h12, 16'hBEEF, 3, 16'h0000, 1'b0};
      vecs[1]  = '{1'b0, 8'h12, 16'h0000, HIT_LAT, 16'hBEEF, !HIT};
      vecs[2]  = '{1'b1, 8'h34, 16'h1234, 3, 16'h0000, 1'b0};
      vecs[3]  = '{1'b0, 8'h55, 16'h0000, RL + 2, 16'h55AA, 1'b1};
      vecs[4]  = '{1'b1, 8'hFF, 16'h0000, 3, 16'h0000, 1'b0};
      vecs[5]  = '{1'b0, 8'hFF, 16'h0000, HIT_LAT, 16'h0000, !HIT};
      vecs[6]  = '{1'b0, 8'h00, 16'h0000, RL + 2, 16'h00FF, 1'b1};
      vecs[7]  = '{1'b0, 8'h34, 16'h0000, RL + 2, 16'h1234, 1'b1};
      vecs[8]  = '{1'b1, 8'h40, 16'h5A5A, 3, 16'h0000, 1'b0};
      vecs[9]  = '{1'b0, 8'h40, 16'h0000, HIT_LAT, 16'h5A5A, !HIT};
      vecs[10] = '{1'b0, 8'h41, 16'h0000, RL + 2, 16'h41BE, 1'b1};

      // Reset held two cycles with a request pending.
      for (int r = 0; r < 2; r++) begin
         step();
         check("rst.ready", req_ready, 0);
         check("rst.rsp_valid", rsp_valid, 0);
         check("rst.ctrl", ram_ctrl, 0);
         check("rst.addr", ram_addr, 0);
         check("rst.din", ram_din, 0);
         check("rst.rdata", rsp_rdata, 0);
      end
      rst       = 1'b0;
      req_valid = 1'b0;
      #1;
      check("rst.ready_after", req_ready, 1);
      check("rst.ready3_after", ready3, 1);

      foreach (vecs[i])
         verify("vec", vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].lat, vecs[i].rdata, vecs[i].re);

      // Back-to-back stores with req_valid held high.
      req_we = 1'b1; req_addr = 8'h60; req_wdata = 16'h1111; req_valid = 1'b1;
      check("b2b.ready0", req_ready, 1);
      step();
      req_addr = 8'h61; req_wdata = 16'h2222;
      check("b2b.we1", ram_ctrl, WE_MASK);
      for (int c = 1; c <= 3; c++) begin
         check("b2b.busy", req_ready, 0);
         step();
      end
      check("b2b.ready4", req_ready, 1);
      step();
      req_valid = 1'b0;
      check("b2b.we5", ram_ctrl, WE_MASK);
      check("b2b.addr5", ram_addr, 8'h61);
      check("b2b.din5", ram_din, 16'h2222);
      step();
      step();
      check("b2b.rsp7", rsp_valid, 1);
      step();
      check("b2b.ready8", req_ready, 1);
      model_apply(1'b1, 8'h60, 16'h1111);
      model_apply(1'b1, 8'h61, 16'h2222);

      // Reset while in RD_WAIT drops the load.
      req_we = 1'b0; req_addr = 8'h60; req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      check("rdrst.re1", ram_ctrl, RE_MASK);
      step();
      rst = 1'b1;
      step();
      check("rdrst.rsp", rsp_valid, 0);
      check("rdrst.ctrl", ram_ctrl, 0);
      check("rdrst.addr", ram_addr, 0);
      rst = 1'b0;
      #1;
      check("rdrst.idle", req_ready, 1);
      for (int c = 0; c < 3; c++) begin
         step();
         check("rdrst.no_rsp", rsp_valid, 0);
      end
      buf_v = 1'b0;
      last_din = '0;
      verify("rdrst.fresh", 1'b0, 8'h60, 16'h0000, RL + 2, 16'h1111, 1'b1);

      // Randomized run against the reference model.
      for (int n = 0; n < 60; n++) begin
         logic        we;
         logic [7:0]  a;
         logic [15:0] wd;
         bit          hit;
         we  = 1'($urandom_range(0, 1));
         a   = 8'h80 | 8'($urandom_range(0, 7));
         wd  = 16'($urandom);
         hit = model_hit(a);
         for (int g = $urandom_range(0, 2); g > 0; g--) step();
         verify("rand", we, a, wd, we ? 3 : (hit ? 1 : RL + 2), ref_mem[a], !hit);
      end

      // READ_LATENCY=3 instance: store then load, response in cycle 5.
      we3 = 1'b1; a3 = 8'h12; wd3 = 16'hBEEF; v3 = 1'b1;
      step();
      v3 = 1'b0;
      check("lat3.we1", ram_ctrl3, WE_MASK);
      step(); step(); step();
      check("lat3.ready4", ready3, 1);
      we3 = 1'b0; v3 = 1'b1;
      step();
      v3 = 1'b0;
      check("lat3.re1", ram_ctrl3, HIT ? 32'h0 : RE_MASK);
      rsp3_cyc = 0;
      rsp3_data = '0;
      for (int c = 2; c <= 8; c++) begin
         step();
         if (rsp_valid3 && rsp3_cyc == 0) begin
            rsp3_cyc  = c;
            rsp3_data = rsp_rdata3;
         end
      end
      if (!HIT) check("lat3.rsp_cyc", rsp3_cyc, 5);
      check("lat3.rdata", rsp_rdata3, 16'hBEEF);
      if (!HIT) check("lat3.rdata_at_rsp", rsp3_data, 16'hBEEF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Sequencer directly upstream of the `RAM` block that turns single load/store requests from the CPU core into the address, data and `control_signal` pattern the RAM needs. It owns the memory address and buffer registers. It pulses write bit 12 or read bit 5 of the control word for exactly one cycle, and holds address and data stable across the RAM's internally registered write enable. It waits out the block-RAM read latency and returns one response pulse per request.

## Interface
- `ADDR_W`, 8: address width; drives RAM `addr`.
- `DATA_W`, 16: data width; drives RAM `data_in`, receives `data_out`.
- `READ_LATENCY`, 1: RAM clock edges from address sample to valid `data_out`; legal range 1..3.
- `WE_BIT`, 12: control-word bit that requests a RAM write.
- `RE_BIT`, 5: control-word bit that requests a RAM read.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `req_valid`  in  1  core presents a request.
- `req_ready`  out  1  unit can accept; high only in IDLE and while `rst` is low.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  ADDR_W  request address.
- `req_wdata`  in  DATA_W  store data.
- `rsp_valid`  out  1  one-cycle completion pulse; no backpressure.
- `rsp_rdata`  out  DATA_W  load data; holds its value until the next load completes.
- `ram_addr`  out  ADDR_W  to RAM `addr`.
- `ram_din`  out  DATA_W  to RAM `data_in`.
- `ram_dout`  in  DATA_W  from RAM `data_out`.
- `ram_ctrl`  out  32  to RAM `control_signal`; all bits other than `WE_BIT` and `RE_BIT` are always 0.

## Operation
- States: IDLE, WR_ARM, WR_COMMIT, RD_ISSUE, RD_WAIT, RESP.
- Handshake: a request is accepted on a rising edge where `req_valid && req_ready`. On acceptance the unit latches `req_addr` into `ram_addr` and `req_wdata` into `ram_din` (stores only; `ram_din` is otherwise unchanged).
- IDLE -> WR_ARM on store, -> RD_ISSUE on load.
- WR_ARM (1 cycle): `ram_ctrl[WE_BIT]`=1. The RAM registers its write enable at the end of this cycle.
- WR_COMMIT (1 cycle): `ram_ctrl`=0. `ram_addr` and `ram_din` stay held, and the RAM writes at the end of this cycle. Then -> RESP.
- RD_ISSUE (1 cycle): `ram_ctrl[RE_BIT]`=1; the RAM samples `ram_addr`. Then -> RD_WAIT.
- RD_WAIT: a down-counter loaded with `READ_LATENCY`-1 counts to 0. On the 0 cycle, `ram_dout` is captured into `rsp_rdata`. Then -> RESP.
- RESP (1 cycle): `rsp_valid`=1, `req_ready`=0. Then -> IDLE.
- `ram_addr` and `ram_din` hold their last values in IDLE; they never change while in WR_ARM or WR_COMMIT.
- Two control bits are never asserted in the same cycle.

## Timing
- Let cycle 0 end with the accepting edge.
- Store: WE pulse in cycle 1, write commits at the end of cycle 2, `rsp_valid` in cycle 3, `req_ready` high again in cycle 4.
- Load: RE pulse in cycle 1, `rsp_valid` with data in cycle `READ_LATENCY`+2, next accept possible in cycle `READ_LATENCY`+3.
- Throughput: at most one outstanding request.
- Reset values (forced on any edge with `rst`=1, from any state):
  - state returns to IDLE;
  - `ram_ctrl`, `ram_addr`, `ram_din`, `rsp_rdata` are 0;
  - `rsp_valid` is 0;
  - RD_WAIT counter is 0;
  - `req_ready` is 0 during the `rst` cycle.
- Reset mid-operation: the request is dropped and no `rsp_valid` is issued.
  - Reset in WR_ARM: the RAM-side write enable is already registered, so the write may land at the reset-release address (0). The core must re-issue the store.
- `req_valid` while `req_ready`=0 is ignored. The core holds its request until accepted.

## Configuration
- Macro: `MAU_RDBUF_EN`.
- Defined: the unit holds a one-entry read buffer {valid, addr, data}.
  - A store fills the buffer with its address and data and sets valid. The buffer updates at WR_COMMIT.
  - A completed load fills the buffer with its address and captured data.
  - A load hitting a valid entry goes IDLE -> RESP: `rsp_valid` in cycle 1, `RE_BIT` never asserted, and `rsp_rdata` is the buffered data.
  - `rst` clears valid.
- Undefined: no buffer registers exist, and every load takes the RD_ISSUE/RD_WAIT path.

## Test plan
- Reset: hold `rst` high for 2 cycles with `req_valid`=1 -> all outputs 0 and `req_ready`=0 during reset. `req_ready`=1 on the first cycle after release.
- Store 0xBEEF to 0x12 -> `ram_ctrl`=0x0000_1000 in cycle 1 only. `ram_addr`=0x12 and `ram_din`=0xBEEF are stable in cycles 1-2. `rsp_valid` is high in cycle 3 only.
- Load 0x12 after that store (macro off, `READ_LATENCY`=1) -> `ram_ctrl`=0x0000_0020 in cycle 1 only; `rsp_valid` with `rsp_rdata`=0xBEEF in cycle 3. Repeat with `READ_LATENCY`=3 -> response in cycle 5.
- Back-to-back: `req_valid` held high with two stores -> `req_ready`=0 in cycles 1-3. The second store is accepted at the end of cycle 4, and its WE pulse is in cycle 5.
- Reset asserted in RD_WAIT -> no `rsp_valid`, `ram_ctrl`=0 and IDLE on the next cycle, and a fresh load completes normally.
- Macro on: store 0x5A5A to 0x40, then load 0x40 -> `rsp_rdata`=0x5A5A in cycle 1 with `RE_BIT` never asserted. Then load 0x41 -> full RAM read path with RE pulse.
